// File: rtl/vdp_pkg.sv
// Shared VDP timing types: one axis of sync timing plus a table of standard modes.
package vdp_pkg;

    localparam int TIMING_W = 16;

    typedef logic [TIMING_W-1:0] tval_t;

    // fp = active end, sync = sync start, bp = sync end, total = axis length
    typedef struct packed {
        tval_t fp;
        tval_t sync;
        tval_t bp;
        tval_t total;
        logic  neg;
    } timing_t;

    typedef enum logic [1:0] {
        RES_640X400  = 2'd0,
        RES_640X480  = 2'd1,
        RES_720X400  = 2'd2,
        RES_1280X720 = 2'd3
    } res_e;

    function automatic timing_t make_timing(input int fp, input int sync, input int bp,
                                            input int total, input logic neg);
        timing_t t;
        t.fp    = tval_t'(fp);
        t.sync  = tval_t'(sync);
        t.bp    = tval_t'(bp);
        t.total = tval_t'(total);
        t.neg   = neg;
        return t;
    endfunction

    localparam timing_t [0:3] RES_H = {
        make_timing(640,  656,  752,  800,  1'b1),
        make_timing(640,  656,  752,  800,  1'b1),
        make_timing(720,  738,  846,  900,  1'b1),
        make_timing(1280, 1390, 1430, 1650, 1'b0)
    };

    localparam timing_t [0:3] RES_V = {
        make_timing(400, 412, 414, 449, 1'b0),
        make_timing(480, 490, 492, 525, 1'b1),
        make_timing(400, 412, 414, 449, 1'b0),
        make_timing(720, 725, 730, 750, 1'b0)
    };

endpackage

// File: rtl/video_timing_gen_if.sv
// Programming and video-output bundle of the timing generator.
interface video_timing_gen_if #(
    parameter int H_W     = 12,
    parameter int V_W     = 12,
    parameter int SCALE_W = 2
);
    logic               en;
    logic [H_W-1:0]     h_fp, h_sync, h_bp, h_total;
    logic [V_W-1:0]     v_fp, v_sync, v_bp, v_total;
    logic               h_neg, v_neg;
    logic [SCALE_W-1:0] h_scale, v_scale;

    logic               hsync, vsync, de;
    logic [H_W-1:0]     px_x;
    logic [V_W-1:0]     px_y;
    logic               fetch;
    logic [V_W-1:0]     fetch_y;
    logic               frame_start, vblank;

    modport master (
        input  en, h_fp, h_sync, h_bp, h_total, v_fp, v_sync, v_bp, v_total,
               h_neg, v_neg, h_scale, v_scale,
        output hsync, vsync, de, px_x, px_y, fetch, fetch_y, frame_start, vblank
    );

    modport slave (
        output en, h_fp, h_sync, h_bp, h_total, v_fp, v_sync, v_bp, v_total,
               h_neg, v_neg, h_scale, v_scale,
        input  hsync, vsync, de, px_x, px_y, fetch, fetch_y, frame_start, vblank
    );
endinterface

// File: rtl/video_timing_gen_timing_axis.sv
// One timing axis: wrapping counter with shadowed edges and active/sync decode.
module video_timing_gen_timing_axis
    import vdp_pkg::*;
#(
    parameter int      W   = 12,
    parameter timing_t DEF = '0
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         step,
    input  logic         load,
    input  timing_t      cfg,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         active,
    output logic         sync_on,
    output logic         neg,
    output tval_t        fp
);
    localparam int XW = TIMING_W + 1;

    timing_t       sh;
    logic [XW-1:0] cnt_x;
    logic [XW-1:0] nxt_x;

    // Compare cnt+1 against total so totals of 0 or 1 wrap every step.
    assign cnt_x   = XW'(cnt);
    assign nxt_x   = cnt_x + XW'(1);
    assign last    = nxt_x >= {1'b0, sh.total};
    assign active  = cnt_x < {1'b0, sh.fp};
    assign sync_on = (cnt_x >= {1'b0, sh.sync}) && (cnt_x < {1'b0, sh.bp});
    assign neg     = sh.neg;
    assign fp      = sh.fp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= DEF;
            cnt <= '0;
        end else begin
            if (load) sh <= cfg;
            if (!run) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= last ? '0 : cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable VGA/DVI timing generator: sync, DE, scaled pixel coordinates,
// line-buffer fetch requests and frame/vblank strobes in the pixel clock domain.
module video_timing_gen
    import vdp_pkg::*;
#(
    parameter int H_W         = 12,
    parameter int V_W         = 12,
    parameter int SCALE_W     = 2,
    parameter int DEF_H_FP    = int'(RES_H[RES_640X400].fp),
    parameter int DEF_H_SYNC  = int'(RES_H[RES_640X400].sync),
    parameter int DEF_H_BP    = int'(RES_H[RES_640X400].bp),
    parameter int DEF_H_TOTAL = int'(RES_H[RES_640X400].total),
    parameter int DEF_V_FP    = int'(RES_V[RES_640X400].fp),
    parameter int DEF_V_SYNC  = int'(RES_V[RES_640X400].sync),
    parameter int DEF_V_BP    = int'(RES_V[RES_640X400].bp),
    parameter int DEF_V_TOTAL = int'(RES_V[RES_640X400].total),
    parameter bit DEF_H_NEG   = RES_H[RES_640X400].neg,
    parameter bit DEF_V_NEG   = RES_V[RES_640X400].neg
)(
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master bus
);
    localparam timing_t DEF_H = make_timing(DEF_H_FP, DEF_H_SYNC, DEF_H_BP, DEF_H_TOTAL, DEF_H_NEG);
    localparam timing_t DEF_V = make_timing(DEF_V_FP, DEF_V_SYNC, DEF_V_BP, DEF_V_TOTAL, DEF_V_NEG);

    timing_t            cfg_h, cfg_v;
    logic [H_W-1:0]     h_cnt;
    logic [V_W-1:0]     v_cnt;
    logic               h_last, v_last, h_act, v_act, h_sync_on, v_sync_on;
    logic               h_neg_sh, v_neg_sh;
    tval_t              h_fp_sh, v_fp_sh;
    logic [SCALE_W-1:0] h_scale_sh, v_scale_sh;
    logic               load;

    always_comb begin
        cfg_h = make_timing(int'(bus.h_fp), int'(bus.h_sync), int'(bus.h_bp),
                            int'(bus.h_total), bus.h_neg);
        cfg_v = make_timing(int'(bus.v_fp), int'(bus.v_sync), int'(bus.v_bp),
                            int'(bus.v_total), bus.v_neg);
    end

    // Programming lands only between frames, or continuously while stopped.
    assign load = !bus.en || (h_last && v_last);

    video_timing_gen_timing_axis #(.W(H_W), .DEF(DEF_H)) u_h_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (bus.en),
        .step    (1'b1),
        .load    (load),
        .cfg     (cfg_h),
        .cnt     (h_cnt),
        .last    (h_last),
        .active  (h_act),
        .sync_on (h_sync_on),
        .neg     (h_neg_sh),
        .fp      (h_fp_sh)
    );

    video_timing_gen_timing_axis #(.W(V_W), .DEF(DEF_V)) u_v_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (bus.en),
        .step    (h_last),
        .load    (load),
        .cfg     (cfg_v),
        .cnt     (v_cnt),
        .last    (v_last),
        .active  (v_act),
        .sync_on (v_sync_on),
        .neg     (v_neg_sh),
        .fp      (v_fp_sh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_scale_sh <= '0;
            v_scale_sh <= '0;
        end else if (load) begin
            h_scale_sh <= bus.h_scale;
            v_scale_sh <= bus.v_scale;
        end
    end

    // Fetch decision at start of hblank for the line about to be displayed.
    logic [V_W-1:0] nv, nv_s, v_s;
    logic           fetch_now, de_now;

    assign nv        = v_last ? '0 : v_cnt + V_W'(1);
    assign nv_s      = nv >> v_scale_sh;
    assign v_s       = v_cnt >> v_scale_sh;
    assign fetch_now = (TIMING_W'(h_cnt) == h_fp_sh) && (TIMING_W'(nv) < v_fp_sh) &&
                       ((nv == '0) || (nv_s != v_s));
    assign de_now    = h_act && v_act;

    // Stage p1: registered decode of the counter state.
    logic           hsync_p1, vsync_p1, de_p1, fetch_p1, frame_start_p1, vblank_p1;
    logic [H_W-1:0] px_x_p1;
    logic [V_W-1:0] px_y_p1, fetch_y_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p1       <= DEF_H_NEG;
            vsync_p1       <= DEF_V_NEG;
            de_p1          <= 1'b0;
            px_x_p1        <= '0;
            px_y_p1        <= '0;
            fetch_p1       <= 1'b0;
            fetch_y_p1     <= '0;
            frame_start_p1 <= 1'b0;
            vblank_p1      <= 1'b0;
        end else if (!bus.en) begin
            hsync_p1       <= h_neg_sh;
            vsync_p1       <= v_neg_sh;
            de_p1          <= 1'b0;
            px_x_p1        <= '0;
            px_y_p1        <= '0;
            fetch_p1       <= 1'b0;
            fetch_y_p1     <= '0;
            frame_start_p1 <= 1'b0;
            vblank_p1      <= 1'b0;
        end else begin
            hsync_p1       <= h_sync_on ^ h_neg_sh;
            vsync_p1       <= v_sync_on ^ v_neg_sh;
            de_p1          <= de_now;
            px_x_p1        <= de_now ? (h_cnt >> h_scale_sh) : '0;
            px_y_p1        <= de_now ? (v_cnt >> v_scale_sh) : '0;
            fetch_p1       <= fetch_now;
            fetch_y_p1     <= fetch_now ? nv_s : '0;
            frame_start_p1 <= (h_cnt == '0) && (v_cnt == '0);
            vblank_p1      <= !v_act;
        end
    end

    assign bus.hsync       = hsync_p1;
    assign bus.vsync       = vsync_p1;
    assign bus.de          = de_p1;
    assign bus.px_x        = px_x_p1;
    assign bus.px_y        = px_y_p1;
    assign bus.fetch       = fetch_p1;
    assign bus.fetch_y     = fetch_y_p1;
    assign bus.frame_start = frame_start_p1;
    assign bus.vblank      = vblank_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small 14x7 test timing.
module tb_video_timing_gen;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [11:0] px_x;
        logic [11:0] px_y;
        logic        fetch;
        logic [11:0] fetch_y;
        logic        frame_start;
        logic        vblank;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    video_timing_gen_if #(.H_W(12), .V_W(12), .SCALE_W(2)) bus ();

    video_timing_gen #(.H_W(12), .V_W(12), .SCALE_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t  eq[$];
    string nq[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Position and latched-programming tracker for expected values
    int hh, vv, tot, s_hs, s_vs;
    bit s_hn, s_vn;

    function automatic void load_shadow();
        tot  = int'(bus.h_total);
        s_hn = bus.h_neg;
        s_vn = bus.v_neg;
        s_hs = int'(bus.h_scale);
        s_vs = int'(bus.v_scale);
    endfunction

    task automatic check_cond(input bit ok, input string nm);
        n_checks++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t", nm, $time);
        end
    endtask

    function automatic bit at_reset_values();
        return (bus.hsync === 1'b1) && (bus.vsync === 1'b0) && (bus.de === 1'b0) &&
               (bus.px_x === 12'd0) && (bus.px_y === 12'd0) && (bus.fetch === 1'b0) &&
               (bus.fetch_y === 12'd0) && (bus.frame_start === 1'b0) && (bus.vblank === 1'b0);
    endfunction

    // Hand-derived outputs for timing h 8/10/12/tot, v 4/5/6/7
    function automatic exp_t exp_at(input int h, input int v);
        exp_t e = '0;
        e.de          = (h < 8) && (v < 4);
        e.hsync       = ((h == 10) || (h == 11)) ^ s_hn;
        e.vsync       = (v == 5) ^ s_vn;
        e.px_x        = e.de ? 12'(h >> s_hs) : 12'd0;
        e.px_y        = e.de ? 12'(v >> s_vs) : 12'd0;
        e.frame_start = (h == 0) && (v == 0);
        e.vblank      = (v >= 4);
        if (h == 8) begin
            if (v == 6) begin
                e.fetch = 1'b1; e.fetch_y = 12'd0;
            end else if (s_vs == 0 && v <= 2) begin
                e.fetch = 1'b1; e.fetch_y = 12'(v + 1);
            end else if (s_vs == 1 && v == 1) begin
                e.fetch = 1'b1; e.fetch_y = 12'd1;
            end
        end
        return e;
    endfunction

    // Called at a negedge with inputs set for the coming posedge
    task automatic tick(input string nm);
        exp_t e;
        bit   eof;
        e = '0;
        if (!rst_n) begin
            e.hsync = 1'b1;
            hh = 0; vv = 0; tot = 800; s_hn = 1'b1; s_vn = 1'b0; s_hs = 0; s_vs = 0;
        end else if (!bus.en) begin
            e.hsync = s_hn;
            e.vsync = s_vn;
            hh = 0; vv = 0;
            load_shadow();
        end else begin
            e   = exp_at(hh, vv);
            eof = (hh == tot - 1) && (vv == 6);
            hh++;
            if (hh >= tot) begin
                hh = 0;
                vv = (vv == 6) ? 0 : vv + 1;
            end
            if (eof) load_shadow();
        end
        eq.push_back(e);
        nq.push_back(nm);
        @(negedge clk);
    endtask

    task automatic run(input int n, input string nm);
        for (int i = 0; i < n; i++) tick(nm);
    endtask

    // Monitor: compares one queued expectation per cycle, just after the edge
    initial begin
        exp_t  e, a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() > 0) begin
                e  = eq.pop_front();
                nm = nq.pop_front();
                a  = {bus.hsync, bus.vsync, bus.de, bus.px_x, bus.px_y, bus.fetch,
                      bus.fetch_y, bus.frame_start, bus.vblank};
                n_checks++;
                if (a === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s t=%0t got hs=%0b vs=%0b de=%0b x=%0d y=%0d f=%0b fy=%0d fs=%0b vb=%0b want hs=%0b vs=%0b de=%0b x=%0d y=%0d f=%0b fy=%0d fs=%0b vb=%0b",
                             nm, $time, a.hsync, a.vsync, a.de, a.px_x, a.px_y, a.fetch,
                             a.fetch_y, a.frame_start, a.vblank, e.hsync, e.vsync, e.de,
                             e.px_x, e.px_y, e.fetch, e.fetch_y, e.frame_start, e.vblank);
                end
            end
        end
    end

    initial begin
        bit seen_fs;
        rst_n       = 1'b1;
        bus.en      = 1'b0;
        bus.h_fp    = 12'd8;  bus.h_sync = 12'd10; bus.h_bp = 12'd12; bus.h_total = 12'd14;
        bus.v_fp    = 12'd4;  bus.v_sync = 12'd5;  bus.v_bp = 12'd6;  bus.v_total = 12'd7;
        bus.h_neg   = 1'b0;   bus.v_neg  = 1'b0;
        bus.h_scale = 2'd0;   bus.v_scale = 2'd0;
        #2 rst_n = 1'b0;
        #1 check_cond(at_reset_values(), "reset_state_initial");
        @(negedge clk);

        run(2, "reset");
        rst_n = 1'b1;
        run(3, "idle_after_reset");
        bus.en = 1'b1;
        run(200, "basic");
        bus.en = 1'b0;
        run(5, "en_gate_idle");
        bus.en = 1'b1;
        run(40, "en_restart");

        bus.h_neg = 1'b1; rst_n = 1'b0; bus.en = 1'b0;
        #1 check_cond(at_reset_values(), "reset_state_mid_line");
        run(2, "reset_mid_line");
        rst_n = 1'b1;
        run(2, "idle_hneg");
        bus.en = 1'b1;
        run(30, "hneg");

        bus.h_total = 12'd16;
        run(200, "shadow_htotal");

        bus.h_total = 12'd14; bus.h_neg = 1'b0; bus.v_scale = 2'd1;
        run(250, "vscale");

        bus.h_scale = 2'd2;
        run(196, "hscale");

        repeat (3) @(negedge clk);

        seen_fs = 1'b0;
        for (int i = 0; i < 200 && !seen_fs; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_start === 1'b1) seen_fs = 1'b1;
        end
        check_cond(seen_fs, "frame_start_wait_expired");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised, runtime-programmable VGA/DVI timing generator. It is the next generation of the fixed-resolution timing front end inside the VDP, running in the pixel clock domain. It generates sync, display-enable and scaled logical pixel coordinates. It also issues line-buffer fetch requests and frame/vblank strobes for the CPU and the fetch engine.

Parameters:
H_W, 12, width of horizontal counter and timing inputs
V_W, 12, width of vertical counter and timing inputs
SCALE_W, 2, width of scale inputs (shift amount, 1x..8x)
DEF_H_FP/H_SYNC/H_BP/H_TOTAL, 640/656/752/800, reset shadow horizontal timing
DEF_V_FP/V_SYNC/V_BP/V_TOTAL, 400/412/414/449, reset shadow vertical timing
DEF_H_NEG, 1, reset hsync polarity
DEF_V_NEG, 0, reset vsync polarity

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable
h_fp,h_sync,h_bp,h_total  in  H_W each  horizontal edges: active end, sync start, sync end, line length
v_fp,v_sync,v_bp,v_total  in  V_W each  vertical edges, same meaning
h_neg,v_neg  in  1 each  1 = sync active low
h_scale,v_scale  in  SCALE_W each  logical pixel = counter >> scale
hsync,vsync  out  1 each  sync outputs, polarity applied
de  out  1  display enable
px_x  out  H_W  logical x, valid while de
px_y  out  V_W  logical y, valid while de
fetch  out  1  one-cycle request to fill line buffer
fetch_y  out  V_W  logical line to fetch, valid with fetch
frame_start  out  1  one-cycle pulse at h=0,v=0
vblank  out  1  level, high while v_cnt >= v_fp

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values:
  - Shadow registers load DEF_*.
  - Counters are 0.
  - hsync=DEF_H_NEG, vsync=DEF_V_NEG (inactive levels).
  - de, fetch, frame_start, vblank, px_x, px_y and fetch_y are 0.
- Shadowing: all timing, polarity and scale inputs are copied to shadow registers only at end of frame (h_cnt>=sh_h_total-1 && v_cnt>=sh_v_total-1) or while en=0. No mid-frame change is visible.
- Counters:
  - h_cnt increments each enabled cycle and wraps to 0 when h_cnt>=sh_h_total-1.
  - v_cnt increments on h wrap and wraps to 0 when v_cnt>=sh_v_total-1.
  - Use >= so a degenerate total (0 or 1) wraps every cycle with no lockup.
- en=0: counters are forced to 0 synchronously. Outputs go to reset levels, using the shadow polarity. On en rise, counting starts from h=0,v=0 with a frame_start.
- Output decode, all registered, one cycle after the counter state:
  - de = h_cnt<sh_h_fp && v_cnt<sh_v_fp
  - hsync active when sh_h_sync<=h_cnt<sh_h_bp; vsync likewise on v_cnt with the v edges
  - Output level = active XOR neg.
  - px_x = h_cnt>>sh_h_scale; px_y = v_cnt>>sh_v_scale. Both are 0 when de=0.
  - frame_start: pulse when h_cnt==0 && v_cnt==0.
  - vblank = v_cnt>=sh_v_fp.
- Fetch:
  - At h_cnt==sh_h_fp (start of hblank), let nv = next line (0 on v wrap).
  - If nv<sh_v_fp and (nv==0 or nv>>sh_v_scale != v_cnt>>sh_v_scale), pulse fetch with fetch_y = nv>>sh_v_scale.
  - So fetch occurs once per logical line; repeated scaled lines do not refetch.
- Simultaneous events: a shadow load at end of frame takes effect on the first cycle of the new frame. frame_start and the new-frame decode use the new values.
- Reset mid-frame: counters are cleared immediately and all outputs return to reset values. There are no pending strobes.

Decomposition:
- Shared package vdp_pkg holds the DEF_* resolution localparams (640x400, 640x480, 720x400, 1280x720, ...) and a timing struct typedef {fp, sync, bp, total, neg}.
- One natural sub-module, timing_axis: a generic counter with shadowed edges and sync/active decode. It is instantiated twice (horizontal, with wrap output driving the vertical enable). Fetch and scale logic stay in the top.

Test Plan:
- Common setup: small timing h 8/10/12/14, v 4/5/6/7, neg=0, scale 0. Frame period is 98 cycles.
- Basic timing: with the setup, en=1 -> de high 8 of every 14 cycles on lines 0-3; hsync high at h 10-11; vsync high on line 5; frame_start every 98 cycles; vblank on lines 4-6.
- Polarity and reset: assert rst_n=0 mid-line -> all outputs at reset values immediately. Release with h_neg=1 -> hsync low only during h 10-11 after the first shadow load.
- Shadowing: change h_total 14->16 at v=2 -> line length stays 14 until the frame ends, then 16 from the next frame_start.
- Vertical scaling: v_scale=1 -> fetch pulses only before lines 0 and 2, with fetch_y=0 then 1. px_y sequence is 0,0,1,1.
- Horizontal scaling: h_scale=2 -> px_x is 0,0,0,0,1,1,1,1 over the active span and 0 outside de.
- Enable gating: deassert en for 5 cycles mid-frame -> outputs idle. Re-enable -> frame_start on the first cycle and counters restart from 0.
